// File: rtl/instr_sequencer_pkg.sv
// seq_pkg: shared state encoding, NOP opcode and instruction field positions.
package seq_pkg;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, SHOW} state_t;
  typedef enum int {F_DEST = 0, F_SRC2 = 1, F_SRC1 = 2, F_OP = 3} field_t;
  localparam int OP_NOP = 0;
  function automatic int field_lsb(field_t f, int addr_w);
    return int'(f) * addr_w;
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake, datapath and display signals of the sequencer.
interface instr_sequencer_if #(
  parameter int OP_W   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DISP_W = 16
);
  localparam int INS_W  = OP_W + 3 * ADDR_W;
  localparam int NCHUNK = DATA_W / DISP_W;
  localparam int SEL_W  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  logic              ins_valid;
  logic [INS_W-1:0]  ins;
  logic              ins_ready;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dest;
  logic              rd1_en;
  logic              rd2_en;
  logic              wr_en;
  logic [DATA_W-1:0] result_in;
  logic [DATA_W-1:0] wr_data;
  logic [DISP_W-1:0] disp;
  logic [SEL_W-1:0]  disp_sel;
  logic              busy;
  modport master (
    output ins_valid, ins, result_in,
    input  ins_ready, opcode, src1, src2, dest, rd1_en, rd2_en, wr_en, wr_data, disp, disp_sel, busy
  );
  modport slave (
    input  ins_valid, ins, result_in,
    output ins_ready, opcode, src1, src2, dest, rd1_en, rd2_en, wr_en, wr_data, disp, disp_sel, busy
  );
endinterface

// File: rtl/disp_pager.sv
// disp_pager: holds each display chunk HOLD cycles, pulses done on the last chunk's final cycle.
module disp_pager #(
  parameter int HOLD   = 100000000,
  parameter int NCHUNK = 2,
  localparam int CW    = $clog2(HOLD) + 1,
  localparam int SEL_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [CW-1:0]    cnt,
  output logic [SEL_W-1:0] idx,
  output logic             done
);
  logic active;
  logic last;
  assign last = cnt == CW'(HOLD - 1);
  assign done = active && last && idx == SEL_W'(NCHUNK - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
    end else if (active) begin
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) idx <= done ? '0 : idx + SEL_W'(1);
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: single-clock issue FSM sequencing register read, execute, write-back and
// paged display of the result.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int DISP_W   = 16,
  parameter int EXEC_LAT = 1,
  parameter int HOLD     = 100000000,
  parameter bit R0_ZERO  = 1'b0
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);
  localparam int NCHUNK = DATA_W / DISP_W;
  localparam int SEL_W  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int EW     = $clog2(EXEC_LAT) + 1;
  localparam int CW     = $clog2(HOLD) + 1;
  localparam int OP_L   = field_lsb(F_OP, ADDR_W);
  localparam int S1_L   = field_lsb(F_SRC1, ADDR_W);
  localparam int S2_L   = field_lsb(F_SRC2, ADDR_W);
  localparam int DS_L   = field_lsb(F_DEST, ADDR_W);
  state_t                       state;
  logic [EW-1:0]                ecnt;
  logic [CW-1:0]                cnt;
  logic [SEL_W-1:0]             idx;
  logic [SEL_W-1:0]             nxt;
  logic                         start;
  logic                         done;
  logic [NCHUNK-1:0][DISP_W-1:0] chunks;
  assign start    = state == WRITE;
  assign nxt      = idx + SEL_W'(1);
  assign chunks   = bus.wr_data;
  assign bus.busy = ~bus.ins_ready;
  disp_pager #(.HOLD(HOLD), .NCHUNK(NCHUNK)) u_pager (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cnt   (cnt),
    .idx   (idx),
    .done  (done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ecnt          <= '0;
      bus.ins_ready <= 1'b1;
      bus.opcode    <= '0;
      bus.src1      <= '0;
      bus.src2      <= '0;
      bus.dest      <= '0;
      bus.rd1_en    <= 1'b0;
      bus.rd2_en    <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_data   <= '0;
      bus.disp      <= '0;
      bus.disp_sel  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.ins_valid && bus.ins_ready) begin
          bus.opcode <= bus.ins[OP_L +: OP_W];
          bus.src1   <= bus.ins[S1_L +: ADDR_W];
          bus.src2   <= bus.ins[S2_L +: ADDR_W];
          bus.dest   <= bus.ins[DS_L +: ADDR_W];
          if (bus.ins[OP_L +: OP_W] != OP_W'(OP_NOP)) begin
            state         <= READ;
            bus.ins_ready <= 1'b0;
            bus.rd1_en    <= 1'b1;
            bus.rd2_en    <= 1'b1;
          end
        end
        READ: begin
          state      <= EXEC;
          ecnt       <= '0;
          bus.rd1_en <= 1'b0;
          bus.rd2_en <= 1'b0;
        end
        EXEC: if (ecnt == EW'(EXEC_LAT - 1)) begin
          state       <= WRITE;
          bus.wr_data <= bus.result_in;
          bus.wr_en   <= !(R0_ZERO && bus.dest == '0);
        end else begin
          ecnt <= ecnt + EW'(1);
        end
        WRITE: begin
          state        <= SHOW;
          bus.wr_en    <= 1'b0;
          bus.disp     <= chunks[0];
          bus.disp_sel <= '0;
        end
        SHOW: if (done) begin
          state         <= IDLE;
          bus.ins_ready <= 1'b1;
        end else if (cnt == CW'(HOLD - 1)) begin
          bus.disp     <= chunks[nxt];
          bus.disp_sel <= nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: three sequencer configurations checked each cycle against a cycle-offset
// model, plus hand-computed expectations for the key moments.
module tb_instr_sequencer;
  localparam int HOLD   = 3;
  localparam int NCH    = 2;
  localparam int LAT[3] = '{1, 4, 1};
  logic        clk;
  logic        rst[3];
  logic        valid[3];
  logic [15:0] ins[3];
  logic [31:0] res[3];
  logic        o_ready[3], o_busy[3], o_rd1[3], o_rd2[3], o_wr[3], o_sel[3];
  logic [3:0]  o_op[3], o_s1[3], o_s2[3], o_dst[3];
  logic [31:0] o_wd[3];
  logic [15:0] o_disp[3];
  bit          m_act[3];
  int          m_d[3];
  int          m_sel[3];
  logic [3:0]  m_op[3], m_s1[3], m_s2[3], m_dst[3];
  logic [31:0] m_wr[3];
  logic [15:0] m_disp[3];
  bit          armed;
  int          n_pass, n_tot;
  for (genvar g = 0; g < 3; g++) begin : g_d
    instr_sequencer_if #(.OP_W(4), .ADDR_W(4), .DATA_W(32), .DISP_W(16)) bus ();
    assign bus.ins_valid = valid[g];
    assign bus.ins       = ins[g];
    assign bus.result_in = res[g];
    instr_sequencer #(
      .OP_W(4), .ADDR_W(4), .DATA_W(32), .DISP_W(16),
      .EXEC_LAT(LAT[g]), .HOLD(HOLD), .R0_ZERO(g == 2)
    ) dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );
    assign o_ready[g] = bus.ins_ready;
    assign o_busy[g]  = bus.busy;
    assign o_rd1[g]   = bus.rd1_en;
    assign o_rd2[g]   = bus.rd2_en;
    assign o_wr[g]    = bus.wr_en;
    assign o_op[g]    = bus.opcode;
    assign o_s1[g]    = bus.src1;
    assign o_s2[g]    = bus.src2;
    assign o_dst[g]   = bus.dest;
    assign o_wd[g]    = bus.wr_data;
    assign o_disp[g]  = bus.disp;
    assign o_sel[g]   = bus.disp_sel;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input int i, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL dut%0d %s: got %0h expected %0h", i, name, got, exp);
  endtask
  // Advance the model by one cycle using the inputs that were sampled at the edge just passed;
  // afterwards m_d counts cycles since the accepting cycle.
  task automatic step(input int i);
    int l, k;
    l = LAT[i];
    if (rst[i]) begin
      m_act[i] = 0; m_d[i] = 0; m_sel[i] = 0;
      m_op[i] = '0; m_s1[i] = '0; m_s2[i] = '0; m_dst[i] = '0;
      m_wr[i] = '0; m_disp[i] = '0;
      if (i == 0) armed = 1;
    end else if (!m_act[i]) begin
      if (valid[i]) begin
        {m_op[i], m_s1[i], m_s2[i], m_dst[i]} = ins[i];
        if (ins[i][15:12] != 4'd0) begin
          m_act[i] = 1;
          m_d[i]   = 1;
        end
      end
    end else begin
      if (m_d[i] == 1 + l) m_wr[i] = res[i];
      if (m_d[i] == 2 + l + HOLD * NCH) m_act[i] = 0;
      else begin
        m_d[i]++;
        if (m_d[i] >= 3 + l) begin
          k         = (m_d[i] - 3 - l) / HOLD;
          m_disp[i] = 16'(m_wr[i] >> (16 * k));
          m_sel[i]  = k;
        end
      end
    end
  endtask
  task automatic compare(input int i);
    bit wr_exp;
    wr_exp = m_act[i] && m_d[i] == 2 + LAT[i] && !(i == 2 && m_dst[i] == 4'd0);
    chk(i, "ins_ready", 32'(o_ready[i]), 32'(!m_act[i]));
    chk(i, "busy", 32'(o_busy[i]), 32'(m_act[i]));
    chk(i, "rd1_en", 32'(o_rd1[i]), 32'(m_act[i] && m_d[i] == 1));
    chk(i, "rd2_en", 32'(o_rd2[i]), 32'(m_act[i] && m_d[i] == 1));
    chk(i, "wr_en", 32'(o_wr[i]), 32'(wr_exp));
    chk(i, "fields", {16'd0, o_op[i], o_s1[i], o_s2[i], o_dst[i]},
        {16'd0, m_op[i], m_s1[i], m_s2[i], m_dst[i]});
    chk(i, "wr_data", o_wd[i], m_wr[i]);
    chk(i, "disp", 32'(o_disp[i]), 32'(m_disp[i]));
    chk(i, "disp_sel", 32'(o_sel[i]), 32'(m_sel[i]));
  endtask
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(i);
    if (armed) for (int i = 0; i < 3; i++) compare(i);
  endtask
  initial begin
    n_pass = 0; n_tot = 0; armed = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; valid[i] = 0; ins[i] = '0; res[i] = '0;
      m_act[i] = 0; m_d[i] = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) rst[i] = 0;
    tick();
    chk(0, "reset ready", 32'(o_ready[0]), 32'd1);
    chk(0, "reset busy", 32'(o_busy[0]), 32'd0);
    chk(0, "reset disp", 32'(o_disp[0]), 32'd0);
    // basic instruction and two-chunk display paging
    valid[0] = 1; ins[0] = 16'h1234; res[0] = 32'hDEAD_BEEF;
    tick();
    valid[0] = 0;
    chk(0, "t1 rd1", 32'(o_rd1[0]), 32'd1);
    chk(0, "t1 src1", 32'(o_s1[0]), 32'd2);
    chk(0, "t1 src2", 32'(o_s2[0]), 32'd3);
    repeat (2) tick();
    chk(0, "t1 wr_en", 32'(o_wr[0]), 32'd1);
    chk(0, "t1 dest", 32'(o_dst[0]), 32'd4);
    tick();
    chk(0, "t2 disp lo", 32'(o_disp[0]), 32'h0000_BEEF);
    chk(0, "t2 sel lo", 32'(o_sel[0]), 32'd0);
    repeat (3) tick();
    chk(0, "t2 disp hi", 32'(o_disp[0]), 32'h0000_DEAD);
    chk(0, "t2 sel hi", 32'(o_sel[0]), 32'd1);
    repeat (2) tick();
    chk(0, "t2 busy end", 32'(o_ready[0]), 32'd0);
    tick();
    chk(0, "t2 ready", 32'(o_ready[0]), 32'd1);
    // NOP: fields latch, nothing else moves
    valid[0] = 1; ins[0] = 16'h0ABC;
    tick();
    valid[0] = 0;
    chk(0, "t3 ready", 32'(o_ready[0]), 32'd1);
    chk(0, "t3 rd1", 32'(o_rd1[0]), 32'd0);
    chk(0, "t3 disp", 32'(o_disp[0]), 32'h0000_DEAD);
    chk(0, "t3 src1", 32'(o_s1[0]), 32'hA);
    repeat (3) tick();
    // valid held through a whole instruction
    valid[0] = 1; ins[0] = 16'h1567; res[0] = 32'h1357_9BDF;
    tick();
    ins[0] = 16'h2345;
    chk(0, "t4 src1 a", 32'(o_s1[0]), 32'd5);
    repeat (10) tick();
    chk(0, "t4 src1 b", 32'(o_s1[0]), 32'd3);
    chk(0, "t4 op b", 32'(o_op[0]), 32'd2);
    chk(0, "t4 rd1 b", 32'(o_rd1[0]), 32'd1);
    valid[0] = 0;
    repeat (12) tick();
    // reset during a long execute
    valid[1] = 1; ins[1] = 16'h1234; res[1] = 32'hCAFE_F00D;
    tick();
    valid[1] = 0;
    repeat (2) tick();
    rst[1] = 1;
    tick();
    rst[1] = 0;
    chk(1, "t5 ready", 32'(o_ready[1]), 32'd1);
    chk(1, "t5 busy", 32'(o_busy[1]), 32'd0);
    chk(1, "t5 opcode", 32'(o_op[1]), 32'd0);
    chk(1, "t5 wr_data", o_wd[1], 32'd0);
    repeat (10) tick();
    // write to r0 suppressed, display still pages
    valid[2] = 1; ins[2] = 16'h2110; res[2] = 32'hA5A5_5A5A;
    tick();
    valid[2] = 0;
    repeat (2) tick();
    chk(2, "t6 wr_en", 32'(o_wr[2]), 32'd0);
    chk(2, "t6 wr_data", o_wd[2], 32'hA5A5_5A5A);
    tick();
    chk(2, "t6 disp lo", 32'(o_disp[2]), 32'h0000_5A5A);
    repeat (3) tick();
    chk(2, "t6 disp hi", 32'(o_disp[2]), 32'h0000_A5A5);
    repeat (3) tick();
    chk(2, "t6 ready", 32'(o_ready[2]), 32'd1);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
